instruction_sequencer: RTL

Program store and issue engine that supplies the 8-bit instruction stream to the processor's eight-bit control unit.
- Holds a small writable program, walks it with a program counter, and resolves sequencing opcodes (NOP, JMP, HALT) locally.
- Presents every datapath opcode (0000–1011) to the control unit over a valid/ready handshake.
- Sits between the board-level program loader and the control unit's `instruction` input.

---
 rtl/instruction_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: small writable program store plus a fetch/decode/issue
// engine. Sequencing opcodes (NOP, JMP, HALT) are resolved here; datapath
// opcodes are handed to the control unit over a valid/ready handshake.
module instruction_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              start,
  input  logic              stop,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [7:0]        instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic [7:0]        instruction_q, instruction_d;
  logic [7:0]        word_q, word_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];

  logic              prog_open;
  logic              running;
  logic              handshake;
  logic [3:0]        opcode;

  // The program may only be changed while nothing is executing.
  assign prog_open = (state_q == S_IDLE) || (state_q == S_DONE);
  assign running   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE);
  assign handshake = (state_q == S_ISSUE) && instr_valid_q && instr_ready;
  assign opcode    = word_q[7:4];

  // Program store next-state: a single addressed write, only when not busy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (prog_open && prog_we && (prog_addr == ADDR_W'(i))) begin
        mem_d[i] = prog_data;
      end
    end
  end

  // Program store registers; every word comes out of reset as HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'hF0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Sequencer next-state: walk the program, resolve sequencing opcodes locally.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    instruction_d = instruction_q;
    word_d        = word_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        word_d  = mem_q[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          4'hC, 4'hD: begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
          4'hE: begin
            pc_d    = word_q[ADDR_W-1:0];
            state_d = S_FETCH;
          end
          4'hF: begin
            state_d = S_DONE;
          end
          default: begin
            instruction_d = word_q;
            instr_valid_d = 1'b1;
            state_d       = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        if (handshake) begin
          instr_valid_d = 1'b0;
          pc_d          = pc_q + ADDR_W'(1);
          state_d       = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything except a transfer completing on this edge,
    // which is still counted (pc advances) before going idle.
    if (stop && running) begin
      state_d       = S_IDLE;
      instr_valid_d = 1'b0;
      instruction_d = instruction_q;
      pc_d          = handshake ? (pc_q + ADDR_W'(1)) : pc_q;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      instruction_q <= 8'h00;
      word_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      word_q        <= word_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign pc          = pc_q;
  assign busy        = running;
  assign done        = (state_q == S_DONE);

endmodule
